gs_raw_packer: RTL

Sits directly downstream of the signal-acquisition state machine. It consumes that machine's 16-bit raw-sample write strobe, packs sample pairs into 32-bit words and frames each acquisition with a header and a trailer word. It then writes the result into the host-bound 32-bit read FIFO, with an internal buffer that absorbs host back-pressure.

---
 rtl/gs_raw_packer_pkg.sv | 18 +
 rtl/gs_raw_packer_if.sv | 15 +
 rtl/gs_sync_fifo.sv | 63 ++++++
 rtl/gs_raw_packer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gs_raw_packer_pkg.sv
// gs_pkg: shared definitions for the raw-sample packer and its neighbours.
//   gsState_t          output FSM state encoding
//   HDR_MAGIC_DEFAULT  default header tag byte
//   ENTRY_W            width of one buffered entry {last, sample}
package gs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LO,
    HI,
    TRAILER
  } gsState_t;

  localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hA5;
  localparam int         ENTRY_W           = 17;

endpackage

// File: rtl/gs_raw_packer_if.sv
// gs_raw_packer_if: write port towards the host-bound read FIFO.
//   iHost_full     host FIFO is full (driven by the host side)
//   oHost_wren     write enable into the host FIFO
//   o32Host_wdata  32-bit word written into the host FIFO
// master = packer side, slave = host FIFO side.
interface gs_raw_packer_if;

  logic        iHost_full;
  logic        oHost_wren;
  logic [31:0] o32Host_wdata;

  modport master (input iHost_full, output oHost_wren, output o32Host_wdata);
  modport slave  (output iHost_full, input oHost_wren, input o32Host_wdata);

endinterface

// File: rtl/gs_sync_fifo.sv
// gs_sync_fifo: single-clock show-ahead FIFO.
//   iClk, iReset   clock and synchronous active-high reset
//   iPush, iData   write request and data (ignored while full)
//   iPop           read request (ignored while empty)
//   oData          head entry, valid whenever oEmpty is low
//   oEmpty, oFull  status flags
//   oCount         current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module gs_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 128
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iPush,
  input  logic [WIDTH-1:0]       iData,
  input  logic                   iPop,
  output logic [WIDTH-1:0]       oData,
  output logic                   oEmpty,
  output logic                   oFull,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign doPush = iPush & ~oFull;
  assign doPop  = iPop & ~oEmpty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  assign oData  = mem[rdPtr];
  assign oEmpty = (count == '0);
  assign oFull  = (count == (AW+1)'(DEPTH));
  assign oCount = count;

endmodule

// File: rtl/gs_raw_packer.sv
// gs_raw_packer: packs 16-bit raw samples into 32-bit host words and frames
// each acquisition with a header and a checksum trailer.
//   iClk, iReset      clock and synchronous active-high reset
//   iWriteRawSignal   raw-sample strobe, one contiguous run per frame
//   i16RawSignal      raw sample, valid while the strobe is high
//   i8SignSelec       signal id, latched on the strobe rising edge
//   host              write port to the host read FIFO (master side)
//   oOverflow         sticky: a sample was dropped
//   oBusy             a frame is in progress on either side
module gs_raw_packer
  import gs_pkg::*;
#(
  parameter int         BUF_DEPTH = 128,
  parameter int         FRAME_LEN = 67,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iWriteRawSignal,
  input  logic [15:0]       i16RawSignal,
  input  logic [7:0]        i8SignSelec,
  gs_raw_packer_if.master   host,
  output logic              oOverflow,
  output logic              oBusy
);

  localparam int             CW          = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]  RESERVE_LIM = CW'(BUF_DEPTH - 1);

  logic               regValid;
  logic [15:0]        regSample;
  logic [7:0]         pendSel;
  logic               overflow;
  logic               rising;
  logic               pushLast;
  logic               pushOk;
  logic [ENTRY_W-1:0] fifoIn;
  logic [ENTRY_W-1:0] fifoOut;
  logic               fifoEmpty;
  logic               fifoFull;
  logic [CW-1:0]      occ;
  logic               pop;

  gsState_t    state, stateNext;
  logic [31:0] wordReg, wordNext;
  logic        validReg, validNext;
  logic [15:0] loHalf, loHalfNext;
  logic        lastPend, lastPendNext;
  logic [15:0] count, countNext;
  logic [15:0] sum, sumNext;
  logic        wren;
  logic        entLast;
  logic [15:0] entSample;

  // The registered sample is the last of its run when the strobe has already dropped.
  // Non-last samples may not take the final slot, so the frame terminator always fits.
  assign rising   = iWriteRawSignal & ~regValid;
  assign pushLast = ~iWriteRawSignal;
  assign pushOk   = regValid & (pushLast ? ~fifoFull : (occ < RESERVE_LIM));
  assign fifoIn   = {pushLast, regSample};

  // Input capture, pending sign select for the next header, sticky drop flag.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      regValid  <= 1'b0;
      regSample <= '0;
      pendSel   <= '0;
      overflow  <= 1'b0;
    end else begin
      regValid  <= iWriteRawSignal;
      regSample <= i16RawSignal;
      if (rising) pendSel <= i8SignSelec;
      if (regValid && !pushOk) overflow <= 1'b1;
    end
  end

  gs_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(BUF_DEPTH)
  ) uBuf (
    .iClk   (iClk),
    .iReset (iReset),
    .iPush  (pushOk),
    .iData  (fifoIn),
    .iPop   (pop),
    .oData  (fifoOut),
    .oEmpty (fifoEmpty),
    .oFull  (fifoFull),
    .oCount (occ)
  );

  assign entLast   = fifoOut[ENTRY_W-1];
  assign entSample = fifoOut[15:0];

  // State register together with the held output word and frame arithmetic.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= IDLE;
      wordReg  <= '0;
      validReg <= 1'b0;
      loHalf   <= '0;
      lastPend <= 1'b0;
      count    <= '0;
      sum      <= '0;
    end else begin
      state    <= stateNext;
      wordReg  <= wordNext;
      validReg <= validNext;
      loHalf   <= loHalfNext;
      lastPend <= lastPendNext;
      count    <= countNext;
      sum      <= sumNext;
    end
  end

  // Next-state logic. A valid word only moves on when it is actually written;
  // with no valid word, LO/HI pop the buffer as soon as it has an entry.
  always_comb begin
    stateNext    = state;
    wordNext     = wordReg;
    validNext    = validReg;
    loHalfNext   = loHalf;
    lastPendNext = lastPend;
    countNext    = count;
    sumNext      = sum;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          stateNext = HEADER;
          wordNext  = {HDR_MAGIC, pendSel, 16'(FRAME_LEN)};
          validNext = 1'b1;
        end
      end
      HEADER: begin
        if (wren) begin
          stateNext = LO;
          validNext = 1'b0;
          countNext = '0;
          sumNext   = '0;
        end
      end
      LO: begin
        if (validReg) begin
          if (wren) begin
            stateNext = TRAILER;
            wordNext  = {count, sum};
          end
        end else if (!fifoEmpty) begin
          pop       = 1'b1;
          countNext = count + 16'd1;
          sumNext   = sum + entSample;
          if (entLast) begin
            wordNext  = {16'h0000, entSample};
            validNext = 1'b1;
          end else begin
            loHalfNext = entSample;
            stateNext  = HI;
          end
        end
      end
      HI: begin
        if (validReg) begin
          if (wren) begin
            if (lastPend) begin
              stateNext = TRAILER;
              wordNext  = {count, sum};
            end else begin
              stateNext = LO;
              validNext = 1'b0;
            end
          end
        end else if (!fifoEmpty) begin
          pop          = 1'b1;
          countNext    = count + 16'd1;
          sumNext      = sum + entSample;
          wordNext     = {entSample, loHalf};
          validNext    = 1'b1;
          lastPendNext = entLast;
        end
      end
      TRAILER: begin
        if (wren) begin
          stateNext = IDLE;
          validNext = 1'b0;
        end
      end
      default: begin
        stateNext = IDLE;
        validNext = 1'b0;
      end
    endcase
  end

  // Outputs; the write strobe is qualified combinationally by host back-pressure.
  always_comb begin
    wren               = validReg & ~host.iHost_full;
    host.oHost_wren    = wren;
    host.o32Host_wdata = wordReg;
    oOverflow          = overflow;
    oBusy              = (state != IDLE) | ~fifoEmpty | regValid;
  end

endmodule
